// File: rtl/stage_ifetch_queue.sv
// Instruction fetch stage: fetch pointer, fixed-latency memory read tracking
// and a show-ahead prefetch queue feeding decode. Redirect flushes both the
// queue and every in-flight read so no stale opcode ever reaches decode.
module stage_ifetch_queue #(
  parameter int                 A_WIDTH     = 12,
  parameter int                 D_WIDTH     = 8,
  parameter int                 DEPTH       = 4,
  parameter int                 MEM_LATENCY = 1,
  parameter logic [A_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         ice,
  output logic [A_WIDTH-1:0]           ia,
  input  logic [D_WIDTH-1:0]           id,
  input  logic                         redirect,
  input  logic [A_WIDTH-1:0]           redirect_pc,
  output logic [D_WIDTH-1:0]           opcode,
  output logic [A_WIDTH-1:0]           opcode_pc,
  output logic                         drdy,
  input  logic                         ack_in,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW:0] DEPTH_L = (LW + 1)'(DEPTH);

  logic [A_WIDTH-1:0]     fp;
  logic [D_WIDTH-1:0]     q_data [DEPTH];
  logic [A_WIDTH-1:0]     q_pc   [DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [LW-1:0]          count;
  logic [MEM_LATENCY-1:0] pipe_v;
  logic [A_WIDTH-1:0]     pipe_pc [MEM_LATENCY];
  logic [LW:0]            inflight;
  logic [LW:0]            credit_used;
  logic                   pop;
  logic                   push;

  // Credits: every issued read owns a queue slot until it is popped, so a
  // response can never find the queue full.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + (LW + 1)'(pipe_v[i]);
    end
    credit_used = (LW + 1)'(count) + inflight;
  end

  assign drdy      = (count != '0);
  assign pop       = drdy && ack_in;
  assign push      = pipe_v[MEM_LATENCY-1];
  assign ice       = !reset && !redirect && ((credit_used < DEPTH_L) || pop);
  assign ia        = fp;
  assign opcode    = q_data[rd_ptr];
  assign opcode_pc = q_pc[rd_ptr];
  assign level     = count;

  // Fetch pointer, in-flight tracking and queue state; reset beats redirect,
  // redirect beats any pop or arriving response in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fp     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pipe_v <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe_pc[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect) begin
      fp     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pipe_v <= '0;
    end else begin
      if (ice) fp <= fp + A_WIDTH'(1);
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_pc[i] <= pipe_pc[i-1];
      end
      pipe_v[0]  <= ice;
      pipe_pc[0] <= fp;
      if (push) begin
        q_data[wr_ptr] <= id;
        q_pc[wr_ptr]   <= pipe_pc[MEM_LATENCY-1];
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
    end
  end

endmodule
